// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan driver.
package seg7_pkg;

    localparam int unsigned NDIG   = 8;
    localparam int unsigned SEG_W  = 8;
    localparam int unsigned DATA_W = 64;

    localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;
    localparam logic [NDIG-1:0]  AN_OFF    = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}, dp always off.
    localparam logic [SEG_W-1:0] HEX2SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic {
        DM_HEX = 1'b0,
        DM_RAW = 1'b1
    } disp_mode_e;

    typedef struct packed {
        disp_mode_e          mode;
        logic [DATA_W-1:0]   data;
    } disp_word_t;

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational nibble to active-low seven-segment pattern.
module seg7_hex_dec
    import seg7_pkg::*;
(
    input  logic [3:0]       nib_i,
    output logic [SEG_W-1:0] seg_c_o
);

    assign seg_c_o = HEX2SEG[nib_i];

endmodule

// File: rtl/seg7_scan_drv.sv
// Time-multiplexed 8-digit seven-segment driver with double-buffered frames.
module seg7_scan_drv
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned DIV_W    = 17
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [63:0] disp_data_i,
    input  logic        disp_mode_i,
    input  logic        load_i,
    input  logic [7:0]  dig_en_i,
    output logic [7:0]  disp_seg_o,
    output logic [7:0]  disp_an_o,
    output logic        frame_done_o
);

    localparam int unsigned IDX_W = 3;

    logic [DIV_W-1:0] presc_q, presc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    disp_word_t       act_q, act_d;
    disp_word_t       pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [NDIG-1:0]  an_q, an_d;
    logic             fd_q, fd_d;

    logic             tick_c;
    logic             swap_c;
    disp_word_t       word_in_c;
    logic [3:0]       nib_c;
    logic [SEG_W-1:0] hex_seg_c;
    logic [SEG_W-1:0] raw_seg_c;

    assign tick_c    = (presc_q == DIV_W'(SCAN_DIV - 1));
    assign swap_c    = tick_c && (idx_q == IDX_W'(NDIG - 1));
    assign word_in_c = '{mode: disp_mode_e'(disp_mode_i), data: disp_data_i};

    // Prescaler, digit index and frame buffers; a load on the swap edge bypasses pending.
    always_comb begin
        presc_d    = presc_q + DIV_W'(1);
        idx_d      = idx_q;
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (tick_c) begin
            presc_d = '0;
            idx_d   = idx_q + IDX_W'(1);
        end
        if (swap_c) begin
            if (load_i) begin
                act_d = word_in_c;
            end else if (pend_vld_q) begin
                act_d = pend_q;
            end
            pend_vld_d = 1'b0;
        end else if (load_i) begin
            pend_d     = word_in_c;
            pend_vld_d = 1'b1;
        end
    end

    // Segment source for the digit about to be shown, taken from the post-swap frame.
    assign nib_c     = act_d.data[{idx_d, 2'b00} +: 4];
    assign raw_seg_c = act_d.data[{idx_d, 3'b000} +: 8];

    seg7_hex_dec u_hex_dec (
        .nib_i   (nib_c),
        .seg_c_o (hex_seg_c)
    );

    always_comb begin
        seg_d = seg_q;
        an_d  = an_q;
        fd_d  = 1'b0;
        if (tick_c) begin
            fd_d = swap_c;
            if (dig_en_i[idx_d]) begin
                an_d  = ~(NDIG'(1) << idx_d);
                seg_d = (act_d.mode == DM_RAW) ? raw_seg_c : hex_seg_c;
            end else begin
                an_d  = AN_OFF;
                seg_d = SEG_BLANK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            presc_q    <= '0;
            idx_q      <= IDX_W'(NDIG - 1);
            act_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            seg_q      <= SEG_BLANK;
            an_q       <= AN_OFF;
            fd_q       <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            fd_q       <= fd_d;
        end
    end

    assign disp_seg_o   = seg_q;
    assign disp_an_o    = an_q;
    assign frame_done_o = fd_q;

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Directed bench for seg7_scan_drv with SCAN_DIV=4 (32-cycle frames).
module tb_seg7_scan_drv;

    logic        clk;
    logic        rstn;
    logic [63:0] disp_data_i;
    logic        disp_mode_i;
    logic        load_i;
    logic [7:0]  dig_en_i;
    logic [7:0]  disp_seg_o;
    logic [7:0]  disp_an_o;
    logic        frame_done_o;

    int n_cmp;
    int n_bad;

    seg7_scan_drv #(.SCAN_DIV(4), .DIV_W(2)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .disp_data_i  (disp_data_i),
        .disp_mode_i  (disp_mode_i),
        .load_i       (load_i),
        .dig_en_i     (dig_en_i),
        .disp_seg_o   (disp_seg_o),
        .disp_an_o    (disp_an_o),
        .frame_done_o (frame_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance to the negedge where digit 0 of the next frame is visible.
    task automatic wait_fd(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (frame_done_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s: frame_done got none within 64 cycles, want a pulse", name);
        end
    endtask

    task automatic pulse_load(input logic [63:0] data, input logic mode);
        disp_data_i = data;
        disp_mode_i = mode;
        load_i      = 1'b1;
        @(negedge clk);
        load_i      = 1'b0;
    endtask

    task automatic test_reset;
        bit bad;
        rstn = 1'b0;
        skip(3);
        rstn = 1'b1;
        skip(10);
        pulse_load(64'h0000_0000_1111_1111, 1'b0);
        skip(5);
        rstn = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({disp_an_o, disp_seg_o, frame_done_o} !== {8'hFF, 8'hFF, 1'b0}) begin
                n_bad++;
                $display("FAIL reset_out[%0d]: got an=%h seg=%h fd=%b want an=FF seg=FF fd=0",
                         c, disp_an_o, disp_seg_o, frame_done_o);
            end
        end
        rstn = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (frame_done_o !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_fd_early[%0d]: got %b want 0", c, frame_done_o);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({frame_done_o, disp_an_o, disp_seg_o} !== {1'b1, 8'hFE, 8'hC0}) begin
            n_bad++;
            $display("FAIL reset_first_frame: got fd=%b an=%h seg=%h want fd=1 an=FE seg=C0",
                     frame_done_o, disp_an_o, disp_seg_o);
        end
        bad = 1'b0;
        for (int c = 1; c < 32; c++) begin
            @(negedge clk);
            if (frame_done_o !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL reset_fd_gap: got a pulse inside the frame, want none for 31 cycles");
        end
        @(negedge clk);
        n_cmp++;
        if (frame_done_o !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_fd_period: got %b want 1 at 32 cycles", frame_done_o);
        end
    endtask

    task automatic test_hex;
        @(negedge clk);
        rstn = 1'b0;
        skip(2);
        rstn        = 1'b1;
        disp_data_i = 64'h0000_0000_0123_4567;
        disp_mode_i = 1'b0;
        load_i      = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        wait_fd("hex_first_frame");
        n_cmp++;
        if ({disp_an_o, disp_seg_o} !== 16'hFEF8) begin
            n_bad++;
            $display("FAIL hex_d0: got an=%h seg=%h want an=FE seg=F8", disp_an_o, disp_seg_o);
        end
        skip(3);
        n_cmp++;
        if ({disp_an_o, disp_seg_o} !== 16'hFEF8) begin
            n_bad++;
            $display("FAIL hex_d0_hold: got an=%h seg=%h want an=FE seg=F8", disp_an_o, disp_seg_o);
        end
        skip(1);
        n_cmp++;
        if ({disp_an_o, disp_seg_o} !== 16'hFD82) begin
            n_bad++;
            $display("FAIL hex_d1: got an=%h seg=%h want an=FD seg=82", disp_an_o, disp_seg_o);
        end
        skip(24);
        n_cmp++;
        if ({disp_an_o, disp_seg_o} !== 16'h7FC0) begin
            n_bad++;
            $display("FAIL hex_d7: got an=%h seg=%h want an=7F seg=C0", disp_an_o, disp_seg_o);
        end
    endtask

    task automatic test_raw;
        pulse_load(64'hC6F6F6F0_C6F6F6F0, 1'b1);
        wait_fd("raw_frame");
        n_cmp++;
        if ({disp_an_o, disp_seg_o} !== 16'hFEF0) begin
            n_bad++;
            $display("FAIL raw_d0: got an=%h seg=%h want an=FE seg=F0", disp_an_o, disp_seg_o);
        end
        skip(4);
        n_cmp++;
        if ({disp_an_o, disp_seg_o} !== 16'hFDF6) begin
            n_bad++;
            $display("FAIL raw_d1: got an=%h seg=%h want an=FD seg=F6", disp_an_o, disp_seg_o);
        end
        skip(8);
        n_cmp++;
        if ({disp_an_o, disp_seg_o} !== 16'hF7C6) begin
            n_bad++;
            $display("FAIL raw_d3: got an=%h seg=%h want an=F7 seg=C6", disp_an_o, disp_seg_o);
        end
        skip(16);
        n_cmp++;
        if ({disp_an_o, disp_seg_o} !== 16'h7FC6) begin
            n_bad++;
            $display("FAIL raw_d7: got an=%h seg=%h want an=7F seg=C6", disp_an_o, disp_seg_o);
        end
    endtask

    task automatic test_midframe_load;
        pulse_load(64'h0, 1'b0);
        wait_fd("mid_zero_frame");
        n_cmp++;
        if ({disp_an_o, disp_seg_o} !== 16'hFEC0) begin
            n_bad++;
            $display("FAIL mid_d0_zero: got an=%h seg=%h want an=FE seg=C0", disp_an_o, disp_seg_o);
        end
        skip(12);
        pulse_load(64'h0000_0000_FFFF_FFFF, 1'b0);
        n_cmp++;
        if ({disp_an_o, disp_seg_o} !== 16'hF7C0) begin
            n_bad++;
            $display("FAIL mid_d3_kept: got an=%h seg=%h want an=F7 seg=C0", disp_an_o, disp_seg_o);
        end
        skip(3);
        n_cmp++;
        if ({disp_an_o, disp_seg_o} !== 16'hEFC0) begin
            n_bad++;
            $display("FAIL mid_d4_kept: got an=%h seg=%h want an=EF seg=C0", disp_an_o, disp_seg_o);
        end
        skip(12);
        n_cmp++;
        if ({disp_an_o, disp_seg_o} !== 16'h7FC0) begin
            n_bad++;
            $display("FAIL mid_d7_kept: got an=%h seg=%h want an=7F seg=C0", disp_an_o, disp_seg_o);
        end
        wait_fd("mid_next_frame");
        n_cmp++;
        if ({disp_an_o, disp_seg_o} !== 16'hFE8E) begin
            n_bad++;
            $display("FAIL mid_next_d0: got an=%h seg=%h want an=FE seg=8E", disp_an_o, disp_seg_o);
        end
        skip(20);
        n_cmp++;
        if ({disp_an_o, disp_seg_o} !== 16'hDF8E) begin
            n_bad++;
            $display("FAIL mid_next_d5: got an=%h seg=%h want an=DF seg=8E", disp_an_o, disp_seg_o);
        end
    endtask

    task automatic test_swap_load;
        wait_fd("swap_prev_frame");
        skip(31);
        dig_en_i = 8'h0F;
        pulse_load(64'h0000_0000_0000_000A, 1'b0);
        n_cmp++;
        if ({frame_done_o, disp_an_o, disp_seg_o} !== {1'b1, 8'hFE, 8'h88}) begin
            n_bad++;
            $display("FAIL swap_bypass_d0: got fd=%b an=%h seg=%h want fd=1 an=FE seg=88",
                     frame_done_o, disp_an_o, disp_seg_o);
        end
        skip(4);
        n_cmp++;
        if ({disp_an_o, disp_seg_o} !== 16'hFDC0) begin
            n_bad++;
            $display("FAIL swap_d1: got an=%h seg=%h want an=FD seg=C0", disp_an_o, disp_seg_o);
        end
        skip(12);
        n_cmp++;
        if ({disp_an_o, disp_seg_o} !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL blank_d4: got an=%h seg=%h want an=FF seg=FF", disp_an_o, disp_seg_o);
        end
        skip(12);
        n_cmp++;
        if ({disp_an_o, disp_seg_o} !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL blank_d7: got an=%h seg=%h want an=FF seg=FF", disp_an_o, disp_seg_o);
        end
        wait_fd("swap_following_frame");
        n_cmp++;
        if ({disp_an_o, disp_seg_o} !== 16'hFE88) begin
            n_bad++;
            $display("FAIL swap_persist_d0: got an=%h seg=%h want an=FE seg=88", disp_an_o, disp_seg_o);
        end
    endtask

    task automatic test_back_to_back;
        dig_en_i = 8'hFF;
        skip(4);
        pulse_load(64'h0000_0000_1111_1111, 1'b0);
        skip(5);
        pulse_load(64'h0000_0000_2222_2222, 1'b0);
        n_cmp++;
        if ({disp_an_o, disp_seg_o} !== 16'hFBC0) begin
            n_bad++;
            $display("FAIL b2b_current_d2: got an=%h seg=%h want an=FB seg=C0", disp_an_o, disp_seg_o);
        end
        wait_fd("b2b_frame");
        n_cmp++;
        if ({disp_an_o, disp_seg_o} !== 16'hFEA4) begin
            n_bad++;
            $display("FAIL b2b_d0: got an=%h seg=%h want an=FE seg=A4", disp_an_o, disp_seg_o);
        end
        skip(12);
        n_cmp++;
        if ({disp_an_o, disp_seg_o} !== 16'hF7A4) begin
            n_bad++;
            $display("FAIL b2b_d3: got an=%h seg=%h want an=F7 seg=A4", disp_an_o, disp_seg_o);
        end
        skip(16);
        n_cmp++;
        if ({disp_an_o, disp_seg_o} !== 16'h7FA4) begin
            n_bad++;
            $display("FAIL b2b_d7: got an=%h seg=%h want an=7F seg=A4", disp_an_o, disp_seg_o);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rstn        = 1'b0;
        disp_data_i = '0;
        disp_mode_i = 1'b0;
        load_i      = 1'b0;
        dig_en_i    = 8'hFF;
        test_reset();
        test_hex();
        test_raw();
        test_midframe_load();
        test_swap_load();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
